// File: rtl/dff_bist_pkg.sv
// Shared types and LFSR helpers for the flop BIST driver.
// Tap table gives maximal-length Fibonacci polynomials for widths 4..16.
package dff_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LFSR_MAX_W = 16;

  // Bit (e-1) set for every x^e term except the constant.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int width);
    case (width)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0E08;
      13:      return 16'h1C80;
      14:      return 16'h3802;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] state,
                                                       input int width);
    logic [LFSR_MAX_W-1:0] mask;
    logic                  fb;
    mask = LFSR_MAX_W'((32'h1 << width) - 32'h1);
    fb   = ^(state & lfsr_taps(width));
    return {state[LFSR_MAX_W-2:0], fb} & mask;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_bist_driver_if.sv
// Control and flop-datapath bundle between the BIST driver and its surroundings.
// Optional first-fail signals exist only when DFF_BIST_FIRST_FAIL_EN is defined.
interface dff_bist_driver_if
  import dff_bist_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int ERR_W   = 8,
  parameter int NUM_VEC = 256
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] dut_d;
  logic [WIDTH-1:0] dut_q;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
`ifdef DFF_BIST_FIRST_FAIL_EN
  localparam int IDX_W = idx_width(NUM_VEC);
  logic [IDX_W-1:0] fail_idx;
  logic [WIDTH-1:0] fail_mask;
`endif

  modport master (
    input  start, stop, dut_q,
`ifdef DFF_BIST_FIRST_FAIL_EN
    output fail_idx, fail_mask,
`endif
    output dut_d, busy, done, pass, err_count
  );

  modport slave (
    output start, stop, dut_q,
`ifdef DFF_BIST_FIRST_FAIL_EN
    input  fail_idx, fail_mask,
`endif
    input  dut_d, busy, done, pass, err_count
  );

endinterface

// File: rtl/dff_bist_lfsr.sv
// Fibonacci LFSR vector source: shift left, feedback into bit 0.
// Load has priority over enable; reset and load both restore SEED.
module dff_bist_lfsr
  import dff_bist_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_state
);
  logic [WIDTH-1:0]      r_state;
  logic [LFSR_MAX_W-1:0] w_ext;
  logic [LFSR_MAX_W-1:0] w_next_ext;
  logic                  w_unused_hi;

  always_comb begin
    w_ext              = '0;
    w_ext[WIDTH-1:0]   = r_state;
    w_next_ext         = lfsr_next(w_ext, WIDTH);
  end

  // Bits above WIDTH are masked to zero by lfsr_next.
  assign w_unused_hi = ^w_next_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= w_next_ext[WIDTH-1:0];
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/dff_bist_driver.sv
// BIST driver for a flop datapath: streams LFSR vectors out, checks the echo.
// Define DFF_BIST_FIRST_FAIL_EN to add first-mismatch index/mask capture.
module dff_bist_driver
  import dff_bist_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               LATENCY = 1,
  parameter int               NUM_VEC = 256,
  parameter int               ERR_W   = 8,
  parameter logic [WIDTH-1:0] SEED    = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  dff_bist_driver_if.master   bus
);
  localparam int               CNT_W    = idx_width(NUM_VEC);
  localparam logic [CNT_W-1:0] LAST_VEC = CNT_W'(NUM_VEC - 1);
  localparam logic [2:0]       LAST_DRN = 3'(LATENCY - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_vec_cnt;
  logic [2:0]       r_drain_cnt;
  logic [WIDTH-1:0] w_lfsr;
  logic             w_accept;
  logic             w_abort;

  logic [WIDTH-1:0] r_dut_d;
  logic [WIDTH-1:0] w_dut_d_next;
  logic             r_d_valid;
  logic             w_d_valid_next;
  logic             r_busy;
  logic             w_busy_next;
  logic             r_done;
  logic             w_done_next;
  logic             r_pass;
  logic             w_pass_next;
  logic [ERR_W-1:0] r_err_count;
  logic [ERR_W-1:0] w_err_next;

  logic             w_chain_valid [LATENCY+1];
  logic [WIDTH-1:0] w_chain_data  [LATENCY+1];
  logic [WIDTH-1:0] w_fail_bits;
  logic             w_cmp;
  logic             w_mismatch;

  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_abort  = bus.stop && ((r_state == RUN) || (r_state == DRAIN));

  dff_bist_lfsr #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_accept),
    .i_en    (r_state == RUN),
    .o_state (w_lfsr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN: begin
        if (bus.stop)                   w_state_next = IDLE;
        else if (r_vec_cnt == LAST_VEC) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (bus.stop)                     w_state_next = IDLE;
        else if (r_drain_cnt == LAST_DRN) w_state_next = DONE;
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vec_cnt   <= '0;
      r_drain_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_vec_cnt <= '0;
      end else if (r_state == RUN) begin
        r_vec_cnt <= r_vec_cnt + CNT_W'(1);
      end
      r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 3'(1) : 3'(0);
    end
  end

  // Delay line: stage 0 is the registered dut_d, stage LATENCY lines up with dut_q.
  assign w_chain_valid[0] = r_d_valid;
  assign w_chain_data[0]  = r_dut_d;

  generate
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_dly
      logic             r_v;
      logic [WIDTH-1:0] r_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v    <= 1'b0;
          r_data <= '0;
        end else begin
          r_v    <= w_abort ? 1'b0 : w_chain_valid[gi];
          r_data <= w_chain_data[gi];
        end
      end

      assign w_chain_valid[gi+1] = r_v;
      assign w_chain_data[gi+1]  = r_data;
    end
  endgenerate

  assign w_fail_bits = w_chain_data[LATENCY] ^ bus.dut_q;
  assign w_cmp       = w_chain_valid[LATENCY] && !w_abort;
  assign w_mismatch  = w_cmp && (w_fail_bits != '0);

  always_comb begin
    w_dut_d_next   = '0;
    w_d_valid_next = 1'b0;
    if ((r_state == RUN) && !w_abort) begin
      w_dut_d_next   = w_lfsr;
      w_d_valid_next = 1'b1;
    end

    w_busy_next = (w_state_next == RUN) || (w_state_next == DRAIN);
    w_done_next = (r_state == DONE);

    w_err_next = r_err_count;
    if (w_accept) begin
      w_err_next = '0;
    end else if (w_mismatch && (r_err_count != ERR_MAX)) begin
      w_err_next = r_err_count + ERR_W'(1);
    end

    // The last compare lands in the DONE cycle, so pass looks at the updated count.
    w_pass_next = r_pass;
    if (w_accept || w_abort) begin
      w_pass_next = 1'b0;
    end else if (r_state == DONE) begin
      w_pass_next = (w_err_next == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dut_d     <= '0;
      r_d_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_dut_d     <= w_dut_d_next;
      r_d_valid   <= w_d_valid_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_pass      <= w_pass_next;
      r_err_count <= w_err_next;
    end
  end

  assign bus.dut_d     = r_dut_d;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err_count;

`ifdef DFF_BIST_FIRST_FAIL_EN
  logic [CNT_W-1:0] r_cmp_idx;
  logic [CNT_W-1:0] r_fail_idx;
  logic [WIDTH-1:0] r_fail_mask;

  // err_count only grows, so zero means this is the first mismatch of the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmp_idx   <= '0;
      r_fail_idx  <= '0;
      r_fail_mask <= '0;
    end else if (w_accept) begin
      r_cmp_idx   <= '0;
      r_fail_idx  <= '0;
      r_fail_mask <= '0;
    end else begin
      if (w_cmp) begin
        r_cmp_idx <= r_cmp_idx + CNT_W'(1);
      end
      if (w_mismatch && (r_err_count == '0)) begin
        r_fail_idx  <= r_cmp_idx;
        r_fail_mask <= w_fail_bits;
      end
    end
  end

  assign bus.fail_idx  = r_fail_idx;
  assign bus.fail_mask = r_fail_mask;
`endif

endmodule
